// File: rtl/hash_rate_meter_pkg.sv
// Shared types and default sizing for the hash-rate meter.
// Holds the state encoding used by the top-level control FSM.
package hash_rate_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_COUNT_W        = 32;
    localparam int unsigned DEFAULT_WINDOW_SECONDS = 1;
    localparam int unsigned TICK_W                 = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating incrementer with synchronous clear and a sticky saturation flag.
// value/value_sat present the count including this cycle's increment.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             value_sat
);

    logic [WIDTH-1:0] count;
    logic             sat;

    always_comb begin
        value     = count;
        value_sat = sat;
        if (inc) begin
            if (&count) begin
                value_sat = 1'b1;
            end else begin
                value = count + WIDTH'(1);
            end
        end
    end

    // Clear wins over increment; the caller captures value before it is lost.
    always_ff @(posedge clk) begin
        if (!rst_ni || clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else begin
            count <= value;
            sat   <= value_sat;
        end
    end

endmodule

// File: rtl/hash_rate_meter.sv
// Counts completion pulses over windows of WINDOW_SECONDS ticks and publishes
// each window's count through a registered valid/ready output.
module hash_rate_meter
    import hash_rate_meter_pkg::*;
#(
    parameter int unsigned WINDOW_SECONDS = DEFAULT_WINDOW_SECONDS,
    parameter int unsigned COUNT_W        = DEFAULT_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_ni,
    input  logic               enable,
    input  logic               second_tick,
    input  logic               event_i,
    output logic [COUNT_W-1:0] rate_o,
    output logic               rate_sat_o,
    output logic               rate_valid_o,
    input  logic               rate_ready_i,
    output logic               drop_o,
    output logic [31:0]        seconds_o
);

    state_e            state;
    state_e            state_next;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick_last;
    logic              count_evt;
    logic              clr_acc;
    logic              tick_adv;
    logic              sec_inc;
    logic              close;
    logic [COUNT_W-1:0] acc_value;
    logic              acc_sat;

    assign tick_last = ({1'b0, tick_cnt} + 9'd1) == 9'(WINDOW_SECONDS);

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accumulator is held clear outside COUNT so ARM always starts from zero.
    always_comb begin
        state_next = state;
        sec_inc    = 1'b0;
        count_evt  = 1'b0;
        tick_adv   = 1'b0;
        close      = 1'b0;
        clr_acc    = 1'b1;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = ARM;
                ARM: begin
                    if (second_tick) begin
                        state_next = COUNT;
                        sec_inc    = 1'b1;
                    end
                end
                COUNT: begin
                    clr_acc   = 1'b0;
                    count_evt = event_i;
                    if (second_tick) begin
                        sec_inc  = 1'b1;
                        tick_adv = 1'b1;
                        close    = tick_last;
                        clr_acc  = tick_last;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    sat_counter #(
        .WIDTH(COUNT_W)
    ) u_acc (
        .clk      (clk),
        .rst_ni   (rst_ni),
        .clr      (clr_acc),
        .inc      (count_evt),
        .value    (acc_value),
        .value_sat(acc_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_ni || clr_acc) begin
            tick_cnt <= '0;
        end else if (tick_adv) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // A close in the same cycle as a transfer keeps valid high with fresh data.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            rate_o       <= '0;
            rate_sat_o   <= 1'b0;
            rate_valid_o <= 1'b0;
            drop_o       <= 1'b0;
            seconds_o    <= '0;
        end else begin
            if (sec_inc) begin
                seconds_o <= seconds_o + 32'd1;
            end
            if (close) begin
                rate_o       <= acc_value;
                rate_sat_o   <= acc_sat;
                rate_valid_o <= 1'b1;
                if (rate_valid_o && !rate_ready_i) begin
                    drop_o <= 1'b1;
                end
            end else if (rate_valid_o && rate_ready_i) begin
                rate_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hash_rate_meter.sv
// Bench for hash_rate_meter: three instances (window/width variants) share
// stimulus and are compared every cycle against a behavioural model.
module tb_hash_rate_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni, enable, second_tick, event_i, rate_ready_i;
    logic [31:0] rate0;
    logic [3:0]  rate1;
    logic [7:0]  rate2;
    logic [2:0]  sat_v, valid_v, drop_v;
    logic [31:0] secs0, secs1, secs2;

    int errors = 0;
    int checks = 0;

    localparam int     WIN  [3] = '{1, 1, 3};
    localparam longint MAXV [3] = '{64'hFFFF_FFFF, 64'd15, 64'd255};

    hash_rate_meter #(.WINDOW_SECONDS(1), .COUNT_W(32)) dut0 (
        .clk(clk), .rst_ni(rst_ni), .enable(enable), .second_tick(second_tick),
        .event_i(event_i), .rate_o(rate0), .rate_sat_o(sat_v[0]),
        .rate_valid_o(valid_v[0]), .rate_ready_i(rate_ready_i),
        .drop_o(drop_v[0]), .seconds_o(secs0));

    hash_rate_meter #(.WINDOW_SECONDS(1), .COUNT_W(4)) dut1 (
        .clk(clk), .rst_ni(rst_ni), .enable(enable), .second_tick(second_tick),
        .event_i(event_i), .rate_o(rate1), .rate_sat_o(sat_v[1]),
        .rate_valid_o(valid_v[1]), .rate_ready_i(rate_ready_i),
        .drop_o(drop_v[1]), .seconds_o(secs1));

    hash_rate_meter #(.WINDOW_SECONDS(3), .COUNT_W(8)) dut2 (
        .clk(clk), .rst_ni(rst_ni), .enable(enable), .second_tick(second_tick),
        .event_i(event_i), .rate_o(rate2), .rate_sat_o(sat_v[2]),
        .rate_valid_o(valid_v[2]), .rate_ready_i(rate_ready_i),
        .drop_o(drop_v[2]), .seconds_o(secs2));

    // Model: phase 0 = disabled, 1 = waiting for aligning tick, 2 = measuring.
    int     ph     [3];
    longint acc    [3];
    longint tcnt   [3];
    longint rate_m [3];
    longint secs_m [3];
    bit     sat_m  [3];
    bit     rsat_m [3];
    bit     val_m  [3];
    bit     drop_m [3];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (!rst_ni) begin
                ph[k] = 0; acc[k] = 0; tcnt[k] = 0; sat_m[k] = 0;
                rate_m[k] = 0; rsat_m[k] = 0; val_m[k] = 0; drop_m[k] = 0; secs_m[k] = 0;
            end else begin
                bit closed;
                closed = 0;
                if (!enable) begin
                    ph[k] = 0;
                end else if (ph[k] == 0) begin
                    ph[k] = 1;
                end else if (ph[k] == 1) begin
                    if (second_tick) begin
                        ph[k] = 2;
                        secs_m[k] = (secs_m[k] + 1) % (64'd1 << 32);
                    end
                end else begin
                    if (event_i) begin
                        if (acc[k] == MAXV[k]) sat_m[k] = 1;
                        else acc[k] = acc[k] + 1;
                    end
                    if (second_tick) begin
                        secs_m[k] = (secs_m[k] + 1) % (64'd1 << 32);
                        tcnt[k] = tcnt[k] + 1;
                        if (tcnt[k] == WIN[k]) closed = 1;
                    end
                end
                if (closed) begin
                    if (val_m[k] && !rate_ready_i) drop_m[k] = 1;
                    rate_m[k] = acc[k];
                    rsat_m[k] = sat_m[k];
                    val_m[k]  = 1;
                end else if (val_m[k] && rate_ready_i) begin
                    val_m[k] = 0;
                end
                if (ph[k] != 2 || closed) begin
                    acc[k] = 0; tcnt[k] = 0; sat_m[k] = 0;
                end
            end
        end
    endtask

    task automatic compare_model();
        longint ar [3];
        longint as [3];
        ar = '{longint'(rate0), longint'(rate1), longint'(rate2)};
        as = '{longint'(secs0), longint'(secs1), longint'(secs2)};
        for (int k = 0; k < 3; k++) begin
            check($sformatf("model_rate%0d", k), ar[k], rate_m[k]);
            check($sformatf("model_sat%0d", k), longint'(sat_v[k]), longint'(rsat_m[k]));
            check($sformatf("model_valid%0d", k), longint'(valid_v[k]), longint'(val_m[k]));
            check($sformatf("model_drop%0d", k), longint'(drop_v[k]), longint'(drop_m[k]));
            check($sformatf("model_secs%0d", k), as[k], secs_m[k]);
        end
    endtask

    task automatic step(input bit r, input bit en, input bit tk, input bit ev, input bit rdy);
        rst_ni = r; enable = en; second_tick = tk; event_i = ev; rate_ready_i = rdy;
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    typedef struct {
        bit     en, tk, ev, rdy;
        longint rate;
        bit     valid, drop;
        longint secs;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit en, bit tk, bit ev, bit rdy,
                                longint rate, bit valid, bit drop, longint secs);
        vec_t v;
        v.en = en; v.tk = tk; v.ev = ev; v.rdy = rdy;
        v.rate = rate; v.valid = valid; v.drop = drop; v.secs = secs;
        tbl.push_back(v);
    endfunction

    initial begin
        // Directed window sequence on the 1-second, 32-bit instance.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) add(1, 0, 1, 0, 0, 0, 0, 1);
        add(1, 1, 1, 0, 10, 1, 0, 2);
        for (int i = 0; i < 5; i++) add(1, 0, 1, 0, 10, 1, 0, 2);
        add(1, 1, 1, 0, 6, 1, 1, 3);
        add(1, 0, 0, 1, 6, 0, 1, 3);
        add(0, 1, 0, 0, 6, 0, 1, 3);

        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        check("rst_rate", longint'(rate0), 0);
        check("rst_valid", longint'(valid_v[0]), 0);
        check("rst_drop", longint'(drop_v[0]), 0);
        check("rst_secs", longint'(secs0), 0);

        foreach (tbl[i]) begin
            step(1, tbl[i].en, tbl[i].tk, tbl[i].ev, tbl[i].rdy);
            check($sformatf("tbl%0d_rate", i), longint'(rate0), tbl[i].rate);
            check($sformatf("tbl%0d_valid", i), longint'(valid_v[0]), longint'(tbl[i].valid));
            check($sformatf("tbl%0d_drop", i), longint'(drop_v[0]), longint'(tbl[i].drop));
            check($sformatf("tbl%0d_secs", i), longint'(secs0), tbl[i].secs);
        end

        // Saturation on the 4-bit instance, then recovery in the next window.
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        repeat (20) step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        check("sat_rate1", longint'(rate1), 15);
        check("sat_flag1", longint'(sat_v[1]), 1);
        check("sat_rate0", longint'(rate0), 20);
        step(1, 1, 0, 1, 1);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        check("unsat_rate1", longint'(rate1), 3);
        check("unsat_flag1", longint'(sat_v[1]), 0);
        check("unsat_drop1", longint'(drop_v[1]), 0);

        // Ready asserted in the exact cycle of a close.
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 1);
        check("rdyclose_valid", longint'(valid_v[0]), 1);
        check("rdyclose_drop", longint'(drop_v[0]), 0);
        check("rdyclose_rate", longint'(rate0), 1);

        // Three-tick window: nothing published until the third tick.
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        repeat (2) step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        check("win3_t1_valid", longint'(valid_v[2]), 0);
        repeat (3) step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        check("win3_t2_valid", longint'(valid_v[2]), 0);
        repeat (2) step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        check("win3_rate", longint'(rate2), 7);
        check("win3_valid", longint'(valid_v[2]), 1);

        // Enable dropped mid-window discards the partial count.
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        repeat (4) step(1, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        repeat (2) step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        check("reen_rate", longint'(rate0), 2);
        check("reen_valid", longint'(valid_v[0]), 1);
        check("reen_secs", longint'(secs0), 3);

        // Reset in the middle of a window.
        repeat (2) step(1, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0);
        check("midrst_rate", longint'(rate0), 0);
        check("midrst_valid", longint'(valid_v[0]), 0);
        check("midrst_drop", longint'(drop_v[0]), 0);
        check("midrst_secs", longint'(secs0), 0);

        // Randomised traffic with varying event density.
        begin
            int dens;
            dens = 50;
            for (int c = 0; c < 3000; c++) begin
                if (c % 256 == 0) dens = int'($urandom_range(0, 100));
                step($urandom_range(0, 499) != 0,
                     $urandom_range(0, 31) != 0,
                     $urandom_range(0, 7) == 0,
                     int'($urandom_range(0, 99)) < dens,
                     $urandom_range(0, 3) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hash_rate_meter.md
# hash_rate_meter

Measures accelerator throughput by counting single-cycle completion pulses between one-second ticks from the shared tick generator, and publishes one count per measurement window through a valid/ready output. It sits beside the core, consuming the core's per-hash done pulse and the tick generator's `second_tick`. It feeds the status/readout path.

## Interface
Parameters:
- `WINDOW_SECONDS`, default 1: number of ticks per measurement window; legal range 1..255.
- `COUNT_W`, default 32: width of the event accumulator and of `rate_o`.

Ports:
- `clk`, input, 1: sole clock.
- `rst_ni`, input, 1: synchronous, active-low reset.
- `enable`, input, 1: measurement enable.
- `second_tick`, input, 1: one-cycle pulse from the tick generator, once per second.
- `event_i`, input, 1: one-cycle pulse per completed hash; back-to-back pulses are legal.
- `rate_o`, output, COUNT_W: events counted in the last closed window.
- `rate_sat_o`, output, 1: the published window's accumulator saturated.
- `rate_valid_o`, output, 1: `rate_o` and `rate_sat_o` hold an unconsumed result.
- `rate_ready_i`, input, 1: consumer accepts the result.
- `drop_o`, output, 1: sticky flag; a valid result was overwritten before it was accepted.
- `seconds_o`, output, 32: ticks seen while enabled, wrapping modulo 2^32.

## Operation
- There are 3 states: `IDLE`, `ARM` and `COUNT`.
  - `IDLE`: entered on reset or whenever `enable` = 0. Accumulator, tick counter and saturation bit are cleared. `event_i` and `second_tick` are ignored. Output register, `rate_valid_o`, `drop_o` and `seconds_o` hold.
  - `ARM`: entered from `IDLE` on `enable` = 1. Events are ignored. The first `second_tick` moves to `COUNT`, which aligns windows to tick boundaries. This tick increments `seconds_o` and does not close a window.
  - `COUNT`: each `event_i` adds 1 to the accumulator. The accumulator saturates at 2^COUNT_W−1, and the sat bit is set when an increment is attempted at max. Each `second_tick` increments `seconds_o` and the tick counter. The tick that brings the tick counter to `WINDOW_SECONDS` closes the window.
- On window close, the following happen in one clock:
  - `rate_o` ← accumulator including any `event_i` in the closing cycle, and `rate_sat_o` ← sat bit.
  - The accumulator, tick counter and sat bit restart at 0.
  - `rate_valid_o` ← 1.
  - If `rate_valid_o` was already 1 and `rate_ready_i` = 0 in that cycle, `drop_o` ← 1 and the old result is overwritten.
- Handshake:
  - The result transfers in the cycle where `rate_valid_o` and `rate_ready_i` are both 1; `rate_valid_o` then falls next cycle unless a window closes in that same cycle.
  - If a window closes in the same cycle as a transfer, `rate_valid_o` stays 1 with the new data and no drop is flagged.
  - `rate_o` is stable while `rate_valid_o` = 1 and not accepted.
- `drop_o` clears only on reset.
- If `enable` falls mid-window, the partial window is discarded and no result is published. Re-enable re-enters `ARM`.

## Timing
- Reset values: `rate_o` = 0, `rate_sat_o` = 0, `rate_valid_o` = 0, `drop_o` = 0, `seconds_o` = 0, state `IDLE`.
- Reset takes effect on the `clk` edge where `rst_ni` = 0 and overrides every other input in that cycle, including a mid-window reset.
- Publish latency: `rate_valid_o` rises 1 cycle after the closing `second_tick` is sampled.
- `enable` is sampled each cycle.
  - A rising `enable` moves to `ARM` the next cycle; a tick in the same cycle as the rise is ignored.
  - A falling `enable` moves to `IDLE` the next cycle; a tick in that same cycle neither closes a window nor counts toward `seconds_o`.
- All outputs are registered, with no combinational path from any input to any output.

## Structure
- Package `hash_rate_meter_pkg` holds the state enum (`IDLE`, `ARM`, `COUNT`) and the default `COUNT_W` and `WINDOW_SECONDS` constants.
- One sub-module, `sat_counter`, is a parameterised-width saturating incrementer with clear and a sat flag. It is used for the accumulator.
- Tick counter: 8 bits. `seconds_o` counter: plain wrapping.

## Test plan
- WINDOW = 1: enable, tick, 10 events, tick → `rate_o` = 10 and `rate_valid_o` = 1 one cycle after the second tick; `seconds_o` = 2.
- Event coincident with the closing tick, and event coincident with the arming tick → the first is counted in the closing window and the second is not counted; 5 + coincident event → `rate_o` = 6.
- COUNT_W = 4: 20 events in a window → `rate_o` = 15 and `rate_sat_o` = 1; next window with 3 events → `rate_o` = 3 and `rate_sat_o` = 0.
- `rate_ready_i` held at 0 across two window closes → second result visible and `drop_o` = 1. Ready pulsed in the exact cycle of a close → `rate_valid_o` stays 1 with no drop.
- WINDOW = 3: 7 events spread over 3 ticks → single result 7 after the third post-arm tick; no result after ticks 1–2.
- Drop `enable` after 4 events mid-window, re-enable, tick, 2 events, tick → published `rate_o` = 2. Assert `rst_ni` = 0 mid-window → all outputs 0 on the next edge.
